duty_ramp_ctrl: RTL
===================

# duty_ramp_ctrl

- Generates the 8-bit duty-control byte consumed by the PWM output stage.
- Replaces the raw switch bus with two debounced push-buttons plus a parallel load port.
- Maintains a target duty value and ramps the live output toward it one LSB at a time at a programmable rate, so the PWM stage never sees abrupt duty steps.
- Sits directly upstream of the PWM stage; its `duty` output drives that stage's control input.

## Interface

Parameters:
- `DEB_CYCLES`, default 1024: consecutive stable synchronized samples required before a button level is accepted.
- `STEP`, default 16: target increment/decrement per accepted button press, range 1..255.
- `RAMP_DIV`, default 256: clock cycles per one-LSB move of `duty`, range 1..65535.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-high reset.
- `btn_up` in 1: raw, asynchronous up button, active-high.
- `btn_dn` in 1: raw, asynchronous down button, active-high.
- `load_en` in 1: synchronous one-cycle strobe, loads `load_val` into target.
- `load_val` in 8: new target value.
- `duty` out 8: live duty byte to the PWM stage, registered.
- `target` out 8: current target value, registered.
- `busy` out 1: high while `duty != target`, registered.
- `at_min` out 1: high when `target == 0`.
- `at_max` out 1: high when `target == 255`.

## Operation

- **Reset values:** `duty=0`, `target=0`, `busy=0`, `at_min=1`, `at_max=0`, FSM in IDLE, prescaler=0, debouncers report released.
- **Button path (per button):**
  - Raw input passes through a 2-flop synchronizer.
  - The debouncer counts consecutive cycles in which the synchronized level differs from the accepted level. The count clears on any agreeing sample.
  - When the count reaches `DEB_CYCLES`, the accepted level flips.
  - An accepted 0->1 transition emits a one-cycle `press` pulse. Releases emit nothing.
- **Target update priority (per cycle):**
  1. `load_en`: `target <= load_val`. Presses in the same cycle are discarded.
  2. Both `press` pulses in the same cycle: both discarded, target unchanged.
  3. Up press: `target <= min(target + STEP, 255)`, computed at 9 bits then saturated.
  4. Down press: `target <= max(target - STEP, 0)`, computed at 9 bits signed then clamped.
- **FSM states IDLE and RAMP:**
  - IDLE -> RAMP when `duty != target`. The prescaler clears on entry.
  - In RAMP, the prescaler counts 0..RAMP_DIV-1. On the terminal count, `duty` moves one LSB toward the *current* `target` and the prescaler wraps to 0.
  - RAMP -> IDLE when `duty == target` after an update. It also exits if a target change makes them equal, in which case `duty` is not modified.
  - A target change mid-RAMP does not restart the prescaler. Direction follows the new target on the next step.
- **Output flags:**
  - `busy = (state == RAMP)`.
  - `at_min` and `at_max` are registered from the next-cycle target.
- `duty` never overshoots the target and never wraps.

## Timing

- Raw button edge -> `press` pulse: 2 sync cycles + `DEB_CYCLES` cycles + 1 cycle.
- `press` or `load_en` -> `target` updated on the following rising edge. `at_min`, `at_max` update on that same edge.
- `target` change -> `busy` high one cycle later (IDLE->RAMP transition).
- First `duty` step occurs `RAMP_DIV` cycles after RAMP entry. Subsequent steps follow every `RAMP_DIV` cycles.
- Full-scale ramp 0->255 takes `255*RAMP_DIV` cycles after entry.
- With `RAMP_DIV=1`, `duty` moves every cycle.
- Reset asserted mid-ramp or mid-debounce: all state returns to reset values immediately and asynchronously. No press is emitted on deassertion, even if a button is held. A held button must be released and re-pressed.

## Structure

- Package `duty_ctrl_pkg`:
  - FSM state enum (IDLE, RAMP).
  - Constants `DUTY_W=8`, `DUTY_MAX=8'hFF`.
  - Default parameter values.
- Sub-module `btn_debounce`, instantiated twice (up, down).
  - Contains the synchronizer, stable counter, accepted level and rising-edge `press` output.
  - Parameterized by `DEB_CYCLES`; uses the same `clk` and `rst_n`.
- Top contains the target register, prescaler, FSM and flag registers.

## Test plan

Bench parameters: `DEB_CYCLES=4`, `STEP=16`, `RAMP_DIV=2`.

- Reset, then hold `btn_up` 20 cycles -> `target` = 16 exactly 8 cycles after the raw edge. `busy` rises 1 cycle later. `duty` steps 1,2,...,16, one step every 2 cycles. `busy` falls the cycle `duty` reaches 16.
- Glitch `btn_up` high for 3 cycles then low -> no press, `target` stays 0.
- `load_val=250`, `load_en` pulse, then 1 up press after `target`=250 -> `target`=255, `at_max`=1. A further up press leaves 255. Ramp ends at `duty`=255.
- At `target`=10, press down -> `target`=0, `at_min`=1.
- Assert `load_en` with `load_val`=0x80 in the same cycle as an up press -> `target`=0x80. Simultaneous up+down presses -> `target` unchanged.
- Mid-ramp (`duty`=40, `target`=100): `load_en` with `load_val`=20 -> `duty` reverses to 39,38,... and reaches 20. Assert `rst_n` at `duty`=30 -> `duty`=0, `target`=0, `busy`=0 immediately. Release with `btn_up` held -> no press.

Source files
------------

// File: rtl/duty_ctrl_pkg.sv
// duty_ctrl_pkg: shared types and constants for the duty ramp controller
// Provides the ramp FSM state enum, the duty byte width and ceiling,
// and the default parameter values used by the controller and debouncer.
package duty_ctrl_pkg;
  typedef enum logic {IDLE, RAMP} state_t;
  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'hFF;
  localparam int DEF_DEB_CYCLES = 1024;
  localparam int DEF_STEP = 16;
  localparam int DEF_RAMP_DIV = 256;
endpackage

// File: rtl/duty_ramp_ctrl_if.sv
// duty_ramp_ctrl_if: button, load and duty status bundle of the duty ramp controller
// Ports (via modports):
//   btn_up, btn_dn   raw asynchronous push-buttons, active-high
//   load_en/load_val one-cycle target load strobe and value
//   duty, target     live duty byte and target byte
//   busy             ramp in progress
//   at_min, at_max   target at 0 / at 255
interface duty_ramp_ctrl_if;
  import duty_ctrl_pkg::*;
  logic btn_up;
  logic btn_dn;
  logic load_en;
  logic [DUTY_W-1:0] load_val;
  logic [DUTY_W-1:0] duty;
  logic [DUTY_W-1:0] target;
  logic busy;
  logic at_min;
  logic at_max;
  modport master (
    output btn_up, btn_dn, load_en, load_val,
    input duty, target, busy, at_min, at_max
  );
  modport slave (
    input btn_up, btn_dn, load_en, load_val,
    output duty, target, busy, at_min, at_max
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces one raw button, emits a press pulse
// Ports: clk, rst_n (async active-high reset), btn_i raw button,
//        press_o one-cycle pulse on an accepted 0->1 transition.
module btn_debounce
  import duty_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic s1_q, s2_q, acc_q, acc_d, prev_q, press_q, arm_q, arm_d, flip;
  logic [1:0] fill_q;
  logic [CW-1:0] cnt_q, cnt_d;
  // arm_q stays low until a genuine released sample is seen after reset, so a
  // button held through reset cannot produce a press until it is re-pressed
  always_comb begin
    flip = (s2_q != acc_q) && (cnt_q == CW'(DEB_CYCLES - 1));
    cnt_d = (s2_q == acc_q || flip) ? '0 : cnt_q + CW'(1);
    acc_d = acc_q ^ flip;
    arm_d = arm_q | (fill_q[1] & ~s2_q);
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      fill_q <= '0;
      cnt_q <= '0;
      acc_q <= 1'b0;
      prev_q <= 1'b0;
      arm_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      fill_q <= {fill_q[0], 1'b1};
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      prev_q <= acc_q;
      arm_q <= arm_d;
      press_q <= arm_q & acc_q & ~prev_q;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/duty_ramp_ctrl.sv
// duty_ramp_ctrl: target register plus rate-limited one-LSB duty ramp for a PWM stage
// Ports: clk, rst_n (async active-high reset), bus (slave modport) carrying
//        buttons, load strobe/value, duty, target, busy, at_min, at_max.
module duty_ramp_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int STEP = DEF_STEP,
  parameter int RAMP_DIV = DEF_RAMP_DIV
) (
  input logic clk,
  input logic rst_n,
  duty_ramp_ctrl_if.slave bus
);
  localparam logic [15:0] PTERM = 16'(RAMP_DIV - 1);
  localparam logic [8:0] STEP9 = 9'(STEP);
  logic up_press, dn_press, at_min_q, at_max_q;
  state_t state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, target_q, target_d;
  logic [15:0] presc_q, presc_d;
  logic [8:0] up_sum, dn_dif;
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_up), .press_o(up_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dn (
    .clk(clk), .rst_n(rst_n), .btn_i(bus.btn_dn), .press_o(dn_press)
  );
  // dn_dif[8] acts as the sign bit: target - STEP spans -255..254
  always_comb begin
    up_sum = {1'b0, target_q} + STEP9;
    dn_dif = {1'b0, target_q} - STEP9;
    target_d = bus.load_en ? bus.load_val
             : (up_press & dn_press) ? target_q
             : up_press ? (up_sum[8] ? DUTY_MAX : up_sum[7:0])
             : dn_press ? (dn_dif[8] ? '0 : dn_dif[7:0])
             : target_q;
    state_d = state_q;
    duty_d = duty_q;
    presc_d = presc_q;
    if (state_q == IDLE) begin
      if (duty_q != target_q) begin
        state_d = RAMP;
        presc_d = '0;
      end
    end else if (duty_q == target_q) begin
      state_d = IDLE;
    end else if (presc_q == PTERM) begin
      duty_d = (duty_q < target_q) ? duty_q + 8'd1 : duty_q - 8'd1;
      presc_d = '0;
      state_d = (duty_d == target_q) ? IDLE : RAMP;
    end else begin
      presc_d = presc_q + 16'd1;
    end
  end
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= IDLE;
      duty_q <= '0;
      target_q <= '0;
      presc_q <= '0;
      at_min_q <= 1'b1;
      at_max_q <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q <= duty_d;
      target_q <= target_d;
      presc_q <= presc_d;
      at_min_q <= (target_d == '0);
      at_max_q <= (target_d == DUTY_MAX);
    end
  end
  assign bus.duty = duty_q;
  assign bus.target = target_q;
  assign bus.busy = (state_q == RAMP);
  assign bus.at_min = at_min_q;
  assign bus.at_max = at_max_q;
endmodule
